// File: rtl/codeword_loader.sv
// Double-buffered beam codebook: rows stream into the shadow bank, a symbol-boundary
// swap makes the shadow bank active so the code-word buses only change between symbols.
module codeword_loader #(
  parameter int BEAM = 16,
  parameter int ANT  = 32,
  parameter int IW   = 32
) (
  input  logic                             i_clk,
  input  logic                             i_rst_n,
  input  logic [ANT*IW-1:0]                i_wdata,
  input  logic                             i_wvalid,
  input  logic                             i_wlast,
  output logic                             o_wready,
  input  logic                             i_swap,
  output logic [BEAM-1:0][ANT*IW-1:0]      o_code_word_even,
  output logic [BEAM-1:0][ANT*IW-1:0]      o_code_word_odd,
  output logic                             o_cw_valid,
  output logic                             o_load_done,
  output logic                             o_swap_ack,
  output logic                             o_swap_miss,
  output logic                             o_err
);

  localparam int RW   = ANT * IW;
  localparam int ROWS = 2 * BEAM;
  localparam int CW   = $clog2(ROWS);
  localparam logic [CW-1:0] LAST_ROW = CW'(ROWS - 1);

  typedef enum logic {LOAD, PEND} state_t;

  state_t                         state;
  logic [1:0][BEAM-1:0][RW-1:0]   bank_even;
  logic [1:0][BEAM-1:0][RW-1:0]   bank_odd;
  logic                           active_sel;
  logic [CW-1:0]                  wcnt;
  logic                           accept;
  logic                           row_last;

  assign accept   = i_wvalid && o_wready;
  assign row_last = (wcnt == LAST_ROW);

  // Outputs are a plain select of the active bank registers.
  assign o_code_word_even = bank_even[active_sel];
  assign o_code_word_odd  = bank_odd[active_sel];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state       <= LOAD;
      bank_even   <= '0;
      bank_odd    <= '0;
      active_sel  <= 1'b0;
      wcnt        <= '0;
      o_wready    <= 1'b1;
      o_cw_valid  <= 1'b0;
      o_load_done <= 1'b0;
      o_swap_ack  <= 1'b0;
      o_swap_miss <= 1'b0;
      o_err       <= 1'b0;
    end else begin
      o_load_done <= 1'b0;
      o_swap_ack  <= 1'b0;
      o_swap_miss <= 1'b0;
      o_err       <= 1'b0;

      // Accepts only happen in LOAD, so writes never touch the pending bank.
      if (accept) begin
        if (wcnt[0]) bank_odd[~active_sel][wcnt[CW-1:1]]  <= i_wdata;
        else         bank_even[~active_sel][wcnt[CW-1:1]] <= i_wdata;

        if (row_last && i_wlast) begin
          state       <= PEND;
          o_wready    <= 1'b0;
          o_load_done <= 1'b1;
          wcnt        <= '0;
        end else if (row_last || i_wlast) begin
          o_err <= 1'b1;
          wcnt  <= '0;
        end else begin
          wcnt <= wcnt + 1'b1;
        end
      end

      // Swap is judged on the state before this edge; a swap racing the final row misses.
      if (i_swap) begin
        if (state == PEND) begin
          state      <= LOAD;
          o_wready   <= 1'b1;
          active_sel <= ~active_sel;
          o_cw_valid <= 1'b1;
          o_swap_ack <= 1'b1;
        end else begin
          o_swap_miss <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_codeword_loader.sv
// Directed bench for codeword_loader: load/swap, double buffering, framing, misses,
// async reset mid-load and backpressure across the pending state.
module tb_codeword_loader;
  localparam int BEAM = 16;
  localparam int ANT  = 32;
  localparam int IW   = 32;
  localparam int RW   = ANT * IW;

  logic                        clk = 1'b0;
  logic                        rst_n = 1'b0;
  logic [RW-1:0]               wdata = '0;
  logic                        wvalid = 1'b0;
  logic                        wlast = 1'b0;
  logic                        wready;
  logic                        swap = 1'b0;
  logic [BEAM-1:0][RW-1:0]     cw_even;
  logic [BEAM-1:0][RW-1:0]     cw_odd;
  logic                        cw_valid;
  logic                        load_done;
  logic                        swap_ack;
  logic                        swap_miss;
  logic                        err;

  int checks = 0;
  int failures = 0;
  int done_cnt = 0, ack_cnt = 0, miss_cnt = 0, err_cnt = 0;

  codeword_loader #(.BEAM(BEAM), .ANT(ANT), .IW(IW)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_wdata(wdata), .i_wvalid(wvalid),
    .i_wlast(wlast), .o_wready(wready), .i_swap(swap),
    .o_code_word_even(cw_even), .o_code_word_odd(cw_odd), .o_cw_valid(cw_valid),
    .o_load_done(load_done), .o_swap_ack(swap_ack), .o_swap_miss(swap_miss), .o_err(err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (load_done === 1'b1) done_cnt++;
    if (swap_ack === 1'b1)  ack_cnt++;
    if (swap_miss === 1'b1) miss_cnt++;
    if (err === 1'b1)       err_cnt++;
  end

  function automatic logic [RW-1:0] rw(input int v);
    return {ANT{IW'(v)}};
  endfunction

  task automatic load_rows(input int base, input int first, input int count,
                           input int wlast_at, input int swap_a, input int swap_b);
    for (int r = first; r < first + count; r++) begin
      wdata  = rw(base + r);
      wvalid = 1'b1;
      wlast  = (r == wlast_at);
      swap   = (r == swap_a) || (r == swap_b);
      @(posedge clk); #1;
    end
    wvalid = 1'b0;
    wlast  = 1'b0;
    swap   = 1'b0;
  endtask

  task automatic do_swap;
    swap = 1'b1;
    @(posedge clk); #1;
    swap = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk); #1;
    checks++; if (wready !== 1'b1) begin failures++; $display("FAIL reset_wready got=%b exp=1", wready); end
    checks++; if (cw_valid !== 1'b0) begin failures++; $display("FAIL reset_cw_valid got=%b exp=0", cw_valid); end
    checks++; if (cw_even !== '0) begin failures++; $display("FAIL reset_even got=%h exp=0", cw_even[0][IW-1:0]); end
    checks++; if (cw_odd !== '0) begin failures++; $display("FAIL reset_odd got=%h exp=0", cw_odd[0][IW-1:0]); end
    checks++; if ({load_done, swap_ack, swap_miss, err} !== 4'b0) begin
      failures++; $display("FAIL reset_pulses got=%b exp=0000", {load_done, swap_ack, swap_miss, err}); end
  endtask

  task automatic test_load_swap;
    int d0, a0;
    d0 = done_cnt; a0 = ack_cnt;
    load_rows(0, 0, 32, 31, -1, -1);
    checks++; if (wready !== 1'b0) begin failures++; $display("FAIL ls_wready_pend got=%b exp=0", wready); end
    @(negedge clk); #1;
    checks++; if (done_cnt - d0 !== 1) begin failures++; $display("FAIL ls_load_done got=%0d exp=1", done_cnt - d0); end
    checks++; if (cw_even !== '0) begin failures++; $display("FAIL ls_pre_swap got=%h exp=0", cw_even[0][IW-1:0]); end
    do_swap;
    checks++; if (cw_valid !== 1'b1) begin failures++; $display("FAIL ls_cw_valid got=%b exp=1", cw_valid); end
    checks++; if (wready !== 1'b1) begin failures++; $display("FAIL ls_wready got=%b exp=1", wready); end
    for (int b = 0; b < BEAM; b++) begin
      checks++; if (cw_even[b] !== rw(2*b)) begin failures++;
        $display("FAIL ls_even[%0d] got=%h_%h exp=%0d", b, cw_even[b][RW-1 -: IW], cw_even[b][IW-1:0], 2*b); end
      checks++; if (cw_odd[b] !== rw(2*b+1)) begin failures++;
        $display("FAIL ls_odd[%0d] got=%h_%h exp=%0d", b, cw_odd[b][RW-1 -: IW], cw_odd[b][IW-1:0], 2*b+1); end
    end
    repeat (3) @(negedge clk); #1;
    checks++; if (done_cnt - d0 !== 1) begin failures++; $display("FAIL ls_done_once got=%0d exp=1", done_cnt - d0); end
    checks++; if (ack_cnt - a0 !== 1) begin failures++; $display("FAIL ls_ack_once got=%0d exp=1", ack_cnt - a0); end
  endtask

  task automatic test_double_buffer;
    int d0;
    d0 = done_cnt;
    for (int r = 0; r < 32; r++) begin
      wdata = rw(100 + r); wvalid = 1'b1; wlast = (r == 31);
      @(posedge clk); #1;
      checks++; if (cw_even[0] !== rw(0)) begin failures++;
        $display("FAIL db_hold_even0 row=%0d got=%h exp=0", r, cw_even[0][IW-1:0]); end
      checks++; if (cw_odd[15] !== rw(31)) begin failures++;
        $display("FAIL db_hold_odd15 row=%0d got=%h exp=1f", r, cw_odd[15][IW-1:0]); end
    end
    wvalid = 1'b0; wlast = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); #1;
      checks++; if (wready !== 1'b0) begin failures++; $display("FAIL db_wready_low cyc=%0d got=%b exp=0", i, wready); end
    end
    checks++; if (done_cnt - d0 !== 1) begin failures++; $display("FAIL db_load_done got=%0d exp=1", done_cnt - d0); end
    do_swap;
    checks++; if (cw_even[0] !== rw(100)) begin failures++; $display("FAIL db_even0 got=%h exp=64", cw_even[0][IW-1:0]); end
    checks++; if (cw_even[8] !== rw(116)) begin failures++; $display("FAIL db_even8 got=%h exp=74", cw_even[8][IW-1:0]); end
    checks++; if (cw_odd[15] !== rw(131)) begin failures++; $display("FAIL db_odd15 got=%h exp=83", cw_odd[15][IW-1:0]); end
  endtask

  task automatic test_framing;
    int d0, e0;
    d0 = done_cnt; e0 = err_cnt;
    load_rows(200, 0, 6, 5, -1, -1);
    @(negedge clk); #1;
    checks++; if (err_cnt - e0 !== 1) begin failures++; $display("FAIL fr_early_err got=%0d exp=1", err_cnt - e0); end
    checks++; if (wready !== 1'b1) begin failures++; $display("FAIL fr_early_wready got=%b exp=1", wready); end
    checks++; if (done_cnt !== d0) begin failures++; $display("FAIL fr_early_nodone got=%0d exp=%0d", done_cnt, d0); end
    load_rows(200, 0, 32, 31, -1, -1);
    @(negedge clk); #1;
    checks++; if (done_cnt - d0 !== 1) begin failures++; $display("FAIL fr_reload_done got=%0d exp=1", done_cnt - d0); end
    checks++; if (err_cnt - e0 !== 1) begin failures++; $display("FAIL fr_reload_noerr got=%0d exp=1", err_cnt - e0); end
    do_swap;
    checks++; if (cw_even[0] !== rw(200)) begin failures++; $display("FAIL fr_even0 got=%h exp=c8", cw_even[0][IW-1:0]); end
    checks++; if (cw_odd[2] !== rw(205)) begin failures++; $display("FAIL fr_odd2 got=%h exp=cd", cw_odd[2][IW-1:0]); end
    checks++; if (cw_odd[15] !== rw(231)) begin failures++; $display("FAIL fr_odd15 got=%h exp=e7", cw_odd[15][IW-1:0]); end
    d0 = done_cnt; e0 = err_cnt;
    load_rows(300, 0, 32, -1, -1, -1);
    @(negedge clk); #1;
    checks++; if (err_cnt - e0 !== 1) begin failures++; $display("FAIL fr_nolast_err got=%0d exp=1", err_cnt - e0); end
    checks++; if (done_cnt !== d0) begin failures++; $display("FAIL fr_nolast_nodone got=%0d exp=%0d", done_cnt, d0); end
    checks++; if (wready !== 1'b1) begin failures++; $display("FAIL fr_nolast_wready got=%b exp=1", wready); end
    checks++; if (cw_even[0] !== rw(200)) begin failures++; $display("FAIL fr_nolast_hold got=%h exp=c8", cw_even[0][IW-1:0]); end
  endtask

  task automatic test_swap_miss;
    int d0, a0, m0;
    d0 = done_cnt; a0 = ack_cnt; m0 = miss_cnt;
    load_rows(400, 0, 32, 31, 10, 31);
    checks++; if (cw_even[0] !== rw(200)) begin failures++; $display("FAIL sm_hold_even0 got=%h exp=c8", cw_even[0][IW-1:0]); end
    @(negedge clk); #1;
    checks++; if (miss_cnt - m0 !== 2) begin failures++; $display("FAIL sm_miss_count got=%0d exp=2", miss_cnt - m0); end
    checks++; if (ack_cnt !== a0) begin failures++; $display("FAIL sm_no_ack got=%0d exp=%0d", ack_cnt, a0); end
    checks++; if (done_cnt - d0 !== 1) begin failures++; $display("FAIL sm_load_done got=%0d exp=1", done_cnt - d0); end
    checks++; if (wready !== 1'b0) begin failures++; $display("FAIL sm_pend got=%b exp=0", wready); end
    checks++; if (cw_odd[15] !== rw(231)) begin failures++; $display("FAIL sm_hold_odd15 got=%h exp=e7", cw_odd[15][IW-1:0]); end
    do_swap;
    checks++; if (swap_ack !== 1'b1) begin failures++; $display("FAIL sm_later_ack got=%b exp=1", swap_ack); end
    checks++; if (cw_even[0] !== rw(400)) begin failures++; $display("FAIL sm_even0 got=%h exp=190", cw_even[0][IW-1:0]); end
    checks++; if (cw_odd[15] !== rw(431)) begin failures++; $display("FAIL sm_odd15 got=%h exp=1af", cw_odd[15][IW-1:0]); end
  endtask

  task automatic test_async_reset;
    load_rows(500, 0, 18, -1, -1, -1);
    #3 rst_n = 1'b0;
    #1;
    checks++; if (cw_even !== '0) begin failures++; $display("FAIL ar_even got=%h exp=0", cw_even[0][IW-1:0]); end
    checks++; if (cw_odd !== '0) begin failures++; $display("FAIL ar_odd got=%h exp=0", cw_odd[0][IW-1:0]); end
    checks++; if (cw_valid !== 1'b0) begin failures++; $display("FAIL ar_cw_valid got=%b exp=0", cw_valid); end
    checks++; if (wready !== 1'b1) begin failures++; $display("FAIL ar_wready got=%b exp=1", wready); end
    @(negedge clk); rst_n = 1'b1;
    load_rows(600, 0, 32, 31, -1, -1);
    do_swap;
    checks++; if (swap_ack !== 1'b1) begin failures++; $display("FAIL ar_ack got=%b exp=1", swap_ack); end
    checks++; if (cw_valid !== 1'b1) begin failures++; $display("FAIL ar_cw_valid2 got=%b exp=1", cw_valid); end
    checks++; if (cw_even[3] !== rw(606)) begin failures++; $display("FAIL ar_even3 got=%h exp=25e", cw_even[3][IW-1:0]); end
    checks++; if (cw_odd[3] !== rw(607)) begin failures++; $display("FAIL ar_odd3 got=%h exp=25f", cw_odd[3][IW-1:0]); end
  endtask

  task automatic test_backpressure;
    int d0, e0;
    d0 = done_cnt; e0 = err_cnt;
    load_rows(700, 0, 32, 31, -1, -1);
    wdata = rw(800); wvalid = 1'b1; wlast = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      checks++; if (wready !== 1'b0) begin failures++; $display("FAIL bp_wready cyc=%0d got=%b exp=0", i, wready); end
      checks++; if (cw_even[0] !== rw(600)) begin failures++; $display("FAIL bp_hold cyc=%0d got=%h exp=258", i, cw_even[0][IW-1:0]); end
    end
    do_swap;
    checks++; if (wready !== 1'b1) begin failures++; $display("FAIL bp_wready_up got=%b exp=1", wready); end
    checks++; if (cw_even[0] !== rw(700)) begin failures++; $display("FAIL bp_even0 got=%h exp=2bc", cw_even[0][IW-1:0]); end
    checks++; if (cw_odd[15] !== rw(731)) begin failures++; $display("FAIL bp_odd15 got=%h exp=2db", cw_odd[15][IW-1:0]); end
    load_rows(800, 0, 32, 31, -1, -1);
    @(negedge clk); #1;
    checks++; if (done_cnt - d0 !== 2) begin failures++; $display("FAIL bp_done got=%0d exp=2", done_cnt - d0); end
    checks++; if (err_cnt !== e0) begin failures++; $display("FAIL bp_no_err got=%0d exp=%0d", err_cnt, e0); end
    do_swap;
    checks++; if (cw_even[0] !== rw(800)) begin failures++; $display("FAIL bp_even0_b got=%h exp=320", cw_even[0][IW-1:0]); end
    checks++; if (cw_even[7] !== rw(814)) begin failures++; $display("FAIL bp_even7_b got=%h exp=32e", cw_even[7][IW-1:0]); end
    checks++; if (cw_odd[15] !== rw(831)) begin failures++; $display("FAIL bp_odd15_b got=%h exp=33f", cw_odd[15][IW-1:0]); end
  endtask

  initial begin
    test_reset;
    test_load_swap;
    test_double_buffer;
    test_framing;
    test_swap_miss;
    test_async_reset;
    test_backpressure;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/codeword_loader.md
# codeword_loader

Codebook loader that supplies the per-beam even/odd antenna code words consumed by the beam MAC array. It accepts one antenna row per cycle on a valid/ready write port into a shadow bank. On a symbol-boundary swap pulse it atomically exchanges shadow and active banks. The active bank drives the wide parallel code-word buses continuously, so code words never change in the middle of a symbol.

## Interface
- BEAM, 16, number of beams
- ANT, 32, antennas per even/odd group
- IW, 32, bits per antenna code-word element (complex packed)
- i_clk  in  1  clock
- i_rst_n  in  1  asynchronous active-low reset
- i_wdata  in  ANT*IW  one row: all ANT elements for one beam, one parity
- i_wvalid  in  1  row valid
- i_wlast  in  1  marks final row of a load
- o_wready  out  1  shadow bank can accept a row
- i_swap  in  1  single-cycle symbol-boundary pulse
- o_code_word_even  out  [BEAM-1:0][ANT*IW-1:0]  active even code words
- o_code_word_odd  out  [BEAM-1:0][ANT*IW-1:0]  active odd code words
- o_cw_valid  out  1  active bank holds a complete codebook
- o_load_done  out  1  pulse: shadow bank complete, swap pending
- o_swap_ack  out  1  pulse: banks exchanged
- o_swap_miss  out  1  pulse: i_swap with no pending bank
- o_err  out  1  pulse: framing error, partial load discarded

## Operation
- Two banks, A and B, each holding BEAM×2 rows of ANT*IW bits. An `active_sel` bit selects which bank drives the outputs.
- Write order within a load, using row counter `wcnt` 0..2*BEAM-1:
  - row 2b is the even row of beam b;
  - row 2b+1 is the odd row of beam b.
- A row is accepted when i_wvalid && o_wready. It is written into the shadow bank at beam wcnt>>1, parity wcnt[0], and `wcnt` increments.
- States:
  - LOAD: o_wready=1.
  - PEND: shadow complete, o_wready=0.
- LOAD→PEND: on acceptance with wcnt==2*BEAM-1 and i_wlast=1. o_load_done pulses the next cycle and `wcnt` clears.
- Framing errors, both handled the same way: o_err pulses, `wcnt` clears, the partial shadow contents are ignored, and the state stays LOAD.
  - i_wlast=1 accepted with wcnt<2*BEAM-1;
  - wcnt==2*BEAM-1 accepted with i_wlast=0.
- PEND→LOAD: on i_swap. `active_sel` toggles, o_cw_valid is set (sticky until reset), and o_swap_ack pulses.
- i_swap in LOAD: o_swap_miss pulses; the active bank, `wcnt` and shadow are unchanged. This includes a partial load in progress.
- Same-cycle i_swap and final row acceptance: the swap is evaluated against the pre-cycle state. It is a miss, and the load then completes to PEND normally.
- Shadow rows not yet overwritten keep stale data. Only a complete, correctly framed load can reach PEND.
- Reset, asynchronous and valid at any time including mid-load:
  - both banks and `active_sel` cleared to 0;
  - `wcnt`=0, state LOAD.

## Timing
- Reset values:
  - o_code_word_even/odd all 0;
  - o_cw_valid=0;
  - o_wready=1;
  - all pulse outputs 0.
- o_wready is a registered function of state. It is high the first cycle after reset deassertion.
- o_wready drops the cycle after the final row is accepted. It rises the cycle after the i_swap that is accepted in PEND.
- Swap latency: i_swap sampled high at edge N gives new code words, o_cw_valid and o_swap_ack valid after edge N. The code-word outputs come straight from the active bank registers.
- o_load_done, o_err and o_swap_miss are registered, one cycle wide, asserted the cycle after the causing edge.
- Minimum load time is 2*BEAM cycles. Back-to-back rows are accepted with no bubbles.
- Active outputs are stable except in the cycle following an accepted swap.

## Test plan
- **Reset, load and swap:** reset, then load 32 rows with data = {ANT{row index}}, wlast on row 31, then pulse i_swap.
  - o_load_done pulses once; o_swap_ack pulses once.
  - even[b] = {ANT{2b}}, odd[b] = {ANT{2b+1}}; o_cw_valid=1.
- **Double buffer:** after the first swap, load a second codebook with data = row+100 while holding i_swap low.
  - Outputs keep the first codebook throughout.
  - o_wready=0 after row 31 and stays low.
  - i_swap then switches to even[0]={ANT{100}}.
- **Framing errors:**
  - wlast on row 5: o_err pulses, and the next 32 rows load correctly.
  - 32 rows without wlast: o_err pulses and there is no o_load_done.
- **Swap miss:** i_swap in LOAD during row 10, and i_swap in the same cycle as the final row.
  - o_swap_miss pulses and outputs are unchanged.
  - The load still completes to PEND, and a later i_swap succeeds.
- **Async reset mid-load:** assert i_rst_n=0 asynchronously between edges at row 17.
  - Outputs go to 0 immediately and o_wready=1.
  - A fresh 32-row load after release works.
- **Backpressure:** i_wvalid held high continuously across PEND.
  - No row is accepted while o_wready=0.
  - The row counter resumes at 0 after the swap.
